// File: rtl/frame_aligner_pkg.sv
// Frame geometry, default FAS bytes and the alignment state encoding shared by
// the frame aligner and its FAS detector.
package frame_aligner_pkg;

   localparam int unsigned FRAME_ROWS = 4;
   localparam int unsigned FRAME_COLS = 1041;
   localparam int unsigned CRC_COL    = FRAME_COLS - 1;
   localparam int unsigned FAS_LEN    = 6;
   localparam int unsigned ROW_W      = 2;
   localparam int unsigned COL_W      = 11;

   localparam logic [8*FAS_LEN-1:0] FAS_DEFAULT = 48'hF6F6F6282828;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PRESYNC = 2'd1,
      SYNC    = 2'd2
   } state_e;

   function automatic logic is_fas_pos(input logic [ROW_W-1:0] row,
                                       input logic [COL_W-1:0] col);
      return (row == '0) && (col < COL_W'(FAS_LEN));
   endfunction

endpackage

// File: rtl/frame_aligner_fas_detector.sv
// Six-byte receive delay line with a FAS comparator over the newest five stored
// bytes plus the incoming byte; the oldest stored byte is the head of the line.
module fas_detector
   import frame_aligner_pkg::*;
#(
   parameter logic [8*FAS_LEN-1:0] PATTERN = FAS_DEFAULT
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_match,
   output logic [7:0] o_head
);

   logic [FAS_LEN-1:0][7:0] line_q;

   // NOTE: the delay line is reset so that bytes from before a reset can never
   // complete a FAS window afterwards.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         line_q <= '0;
      end else if (i_valid) begin
         line_q <= {line_q[FAS_LEN-2:0], i_data};
      end
   end

   assign o_match = i_valid && ({line_q[FAS_LEN-2:0], i_data} == PATTERN);
   assign o_head  = line_q[FAS_LEN-1];

endmodule

// File: rtl/frame_aligner.sv
// Receive frame aligner: hunts for FAS, confirms lock over frames and emits the
// stream six beats late, labelled with row/column and FAS flags.
module frame_aligner
   import frame_aligner_pkg::*;
#(
   parameter logic [8*FAS_LEN-1:0] FAS_PATTERN = FAS_DEFAULT,
   parameter int unsigned          LOF_FRAMES  = 3
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_data_valid,
   output logic [7:0]  o_frame_data,
   output logic        o_frame_data_valid,
   output logic        o_frame_data_fas,
   output logic [1:0]  o_row_cnt,
   output logic [10:0] o_col_cnt,
   output logic        o_in_frame,
   output logic        o_oof,
   output logic        o_fas_err
);

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(CRC_COL);
   localparam logic [2:0]       LOF_TH   = 3'(LOF_FRAMES);

   state_e           state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [2:0]       miss_q, miss_d;
   logic [2:0]       miss_inc;
   logic             emit, fas_err_d, check, fas_match;
   logic [7:0]       head_byte;

   fas_detector #(.PATTERN(FAS_PATTERN)) u_fas_detector (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_data  (i_rx_data),
      .i_valid (i_rx_data_valid),
      .o_match (fas_match),
      .o_head  (head_byte)
   );

   // The head byte labelled with the last position means the window holds the
   // next frame's FAS.
   assign check    = (row_q == ROW_LAST) && (col_q == COL_LAST);
   assign miss_inc = (miss_q == 3'd7) ? miss_q : miss_q + 3'd1;

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      miss_d    = miss_q;
      emit      = 1'b0;
      fas_err_d = 1'b0;
      if (i_rx_data_valid) begin
         case (state_q)
            HUNT: begin
               if (fas_match) begin
                  state_d = PRESYNC;
                  row_d   = '0;
                  col_d   = '0;
                  miss_d  = '0;
               end
            end
            PRESYNC, SYNC: begin
               emit = 1'b1;
               if (check) begin
                  if (fas_match) begin
                     state_d = SYNC;
                     miss_d  = '0;
                  end else begin
                     fas_err_d = 1'b1;
                     miss_d    = miss_inc;
                     if ((state_q == PRESYNC) || (miss_inc >= LOF_TH)) begin
                        state_d = HUNT;
                        emit    = 1'b0;
                     end
                  end
               end
               if (emit) begin
                  if (col_q == COL_LAST) begin
                     col_d = '0;
                     row_d = (row_q == ROW_LAST) ? '0 : row_q + 2'd1;
                  end else begin
                     col_d = col_q + 11'd1;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   // NOTE: all state updates use non-blocking assignments so every register
   // samples the pre-edge values computed above.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q            <= HUNT;
         row_q              <= '0;
         col_q              <= '0;
         miss_q             <= '0;
         o_frame_data       <= '0;
         o_frame_data_valid <= 1'b0;
         o_frame_data_fas   <= 1'b0;
         o_row_cnt          <= '0;
         o_col_cnt          <= '0;
         o_in_frame         <= 1'b0;
         o_oof              <= 1'b1;
         o_fas_err          <= 1'b0;
      end else begin
         state_q            <= state_d;
         row_q              <= row_d;
         col_q              <= col_d;
         miss_q             <= miss_d;
         o_frame_data_valid <= emit;
         o_fas_err          <= fas_err_d;
         o_in_frame         <= (state_d == SYNC);
         o_oof              <= (state_d == HUNT);
         if (emit) begin
            o_frame_data     <= head_byte;
            o_row_cnt        <= row_q;
            o_col_cnt        <= col_q;
            o_frame_data_fas <= is_fas_pos(row_q, col_q);
         end
      end
   end

endmodule

// File: tb/tb_frame_aligner.sv
// Directed scenario sequence over random frame payloads, checked every cycle
// against a byte-history reference model of the aligner.
module tb_frame_aligner;

   localparam logic [47:0] FAS       = 48'hF6F6F6282828;
   localparam int          ROWS      = 4;
   localparam int          COLS      = 1041;
   localparam int          FBYTES    = ROWS * COLS;
   localparam int          LOF       = 3;
   localparam int          FALSE_POS = 1 * COLS + 100;
   localparam int          RST_POS   = 2 * COLS + 500;

   logic        clk, rst_n, rx_valid;
   logic [7:0]  rx_data;
   logic [7:0]  frame_data;
   logic        frame_valid, frame_fas, in_frame, oof, fas_err;
   logic [1:0]  row_cnt;
   logic [10:0] col_cnt;

   frame_aligner #(.FAS_PATTERN(FAS), .LOF_FRAMES(LOF)) dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_rx_data          (rx_data),
      .i_rx_data_valid    (rx_valid),
      .o_frame_data       (frame_data),
      .o_frame_data_valid (frame_valid),
      .o_frame_data_fas   (frame_fas),
      .o_row_cnt          (row_cnt),
      .o_col_cnt          (col_cnt),
      .o_in_frame         (in_frame),
      .o_oof              (oof),
      .o_fas_err          (fas_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks, errors, cyc, n_fas, n_err;

   // Reference model: every accepted byte since reset, indexed by arrival order.
   logic [7:0]  hist[$];
   int          m_state;  // 0 hunting, 1 presync, 2 sync
   int          m_base;   // history index of the byte that is row 0 col 0
   int          m_miss;
   logic        e_valid, e_fas, e_inf, e_oof, e_err;
   logic [7:0]  e_data;
   logic [1:0]  e_row;
   logic [10:0] e_col;
   logic [7:0]  fr [FBYTES];

   function automatic logic [7:0] fas_byte(input int k);
      logic [47:0] p;
      p = FAS;
      return p[47-8*k -: 8];
   endfunction

   task automatic model_reset();
      hist.delete();
      repeat (6) hist.push_back(8'h00);
      m_state = 0;
      m_base  = 0;
      m_miss  = 0;
      e_valid = 1'b0;
      e_data  = '0;
      e_fas   = 1'b0;
      e_row   = '0;
      e_col   = '0;
      e_inf   = 1'b0;
      e_oof   = 1'b1;
      e_err   = 1'b0;
   endtask

   task automatic model_beat(input logic v, input logic [7:0] d);
      int n, idx, pos;
      bit match, emit;
      e_valid = 1'b0;
      e_err   = 1'b0;
      if (v) begin
         hist.push_back(d);
         n = hist.size() - 1;
         match = 1'b1;
         for (int k = 0; k < 6; k++)
            if (hist[n-5+k] !== fas_byte(k)) match = 1'b0;
         if (m_state == 0) begin
            if (match) begin
               m_state = 1;
               m_base  = n - 5;
               m_miss  = 0;
            end
         end else begin
            idx  = n - 6;
            pos  = (idx - m_base) % FBYTES;
            emit = 1'b1;
            if (pos == FBYTES - 1) begin
               if (match) begin
                  m_state = 2;
                  m_miss  = 0;
               end else begin
                  e_err = 1'b1;
                  if (m_miss < 7) m_miss++;
                  if (m_state == 1 || m_miss >= LOF) begin
                     m_state = 0;
                     emit    = 1'b0;
                  end
               end
            end
            if (emit) begin
               e_valid = 1'b1;
               e_data  = hist[idx];
               e_row   = 2'(pos / COLS);
               e_col   = 11'(pos % COLS);
               e_fas   = (pos < 6);
            end
         end
      end
      e_inf = (m_state == 2);
      e_oof = (m_state == 0);
   endtask

   task automatic compare(input string tag);
      logic [25:0] obs, exp;
      obs = {frame_valid, frame_data, frame_fas, row_cnt, col_cnt, in_frame, oof, fas_err};
      exp = {e_valid, e_data, e_fas, e_row, e_col, e_inf, e_oof, e_err};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d {v,data,fas,row,col,inf,oof,err} obs=%b_%h_%b_%0d_%0d_%b%b%b exp=%b_%h_%b_%0d_%0d_%b%b%b",
                tag, cyc, obs[25], obs[24:17], obs[16], obs[15:14], obs[13:3], obs[2], obs[1], obs[0],
                exp[25], exp[24:17], exp[16], exp[15:14], exp[13:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_n(input string tag, input int obs, input int exp);
      checks++;
      assert (obs == exp) else begin
         errors++;
         $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d);
      @(negedge clk);
      rst_n    = 1'b1;
      rx_valid = v;
      rx_data  = d;
      @(posedge clk);
      model_beat(v, d);
      #1;
      cyc++;
      compare("beat");
      if (fas_err) n_err++;
      if (frame_valid && frame_fas) n_fas++;
   endtask

   task automatic reset_cycle();
      @(negedge clk);
      rst_n    = 1'b0;
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      @(posedge clk);
      model_reset();
      #1;
      cyc++;
      compare("reset");
   endtask

   task automatic gen_frame(input bit corrupt, input int false_pos);
      for (int i = 0; i < FBYTES; i++) fr[i] = 8'($urandom);
      for (int k = 0; k < 6; k++) fr[k] = fas_byte(k);
      if (corrupt) fr[3] = ~fr[3];
      if (false_pos >= 0)
         for (int k = 0; k < 6; k++) fr[false_pos+k] = fas_byte(k);
   endtask

   // mode 0: back-to-back, 1: random idle gaps, 2: valid toggles every cycle
   task automatic send_range(input int lo, input int hi, input int mode);
      for (int i = lo; i < hi; i++) begin
         if (mode == 1 && $urandom_range(0, 4) == 0)
            repeat ($urandom_range(1, 3)) step(1'b0, 8'($urandom));
         else if (mode == 2)
            step(1'b0, 8'($urandom));
         step(1'b1, fr[i]);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      cyc      = 0;
      n_fas    = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = '0;
      model_reset();

      reset_cycle();
      chk("rst_oof", oof, 1'b1);
      chk("rst_in_frame", in_frame, 1'b0);
      chk("rst_valid", frame_valid, 1'b0);

      // Line noise while hunting.
      for (int i = 0; i < 300; i++) step(1'b1, 8'($urandom));
      chk("hunt_oof", oof, 1'b1);

      // Clean lock: first FAS -> presync, second -> sync.
      gen_frame(1'b0, -1);
      send_range(0, FBYTES, 1);
      chk("presync_oof", oof, 1'b0);
      chk("presync_in_frame", in_frame, 1'b0);
      gen_frame(1'b0, -1);
      send_range(0, FBYTES, 1);
      chk("sync_in_frame", in_frame, 1'b1);

      // One full frame in sync crosses the row 3 col 1040 wrap.
      n_fas = 0;
      n_err = 0;
      gen_frame(1'b0, -1);
      send_range(0, FBYTES, 1);
      chk_n("fas_beats_per_frame", n_fas, 6);
      chk_n("sync_no_fas_err", n_err, 0);

      // Two misses are tolerated.
      n_err = 0;
      gen_frame(1'b1, -1);
      send_range(0, FBYTES, 0);
      gen_frame(1'b1, -1);
      send_range(0, FBYTES, 0);
      chk_n("miss_err_pulses", n_err, 2);
      chk("miss_stay_sync", in_frame, 1'b1);

      // Third consecutive miss drops to hunt on the check beat; the same frame
      // carries a false FAS at row 1 col 100.
      gen_frame(1'b1, FALSE_POS);
      send_range(0, 6, 0);
      chk("lof_oof", oof, 1'b1);
      chk("lof_in_frame", in_frame, 1'b0);
      chk("lof_valid_drop", frame_valid, 1'b0);
      chk("lof_fas_err", fas_err, 1'b1);
      send_range(6, FBYTES, 0);
      chk("false_presync_oof", oof, 1'b0);

      gen_frame(1'b0, -1);
      send_range(0, FALSE_POS + 6, 0);
      chk("false_miss_err", fas_err, 1'b1);
      chk("false_miss_oof", oof, 1'b1);
      send_range(FALSE_POS + 6, FBYTES, 0);

      gen_frame(1'b0, -1);
      send_range(0, FBYTES, 0);
      chk("relock_presync_oof", oof, 1'b0);
      gen_frame(1'b0, -1);
      send_range(0, RST_POS, 0);
      chk("relock_sync", in_frame, 1'b1);

      // Reset at row 2 col 500, then relock with valid toggling every cycle.
      reset_cycle();
      chk("midrst_oof", oof, 1'b1);
      chk("midrst_in_frame", in_frame, 1'b0);
      send_range(RST_POS, FBYTES, 2);
      chk("post_rst_hunt", oof, 1'b1);
      gen_frame(1'b0, -1);
      send_range(0, FBYTES, 2);
      chk("post_rst_presync", oof, 1'b0);
      gen_frame(1'b0, -1);
      send_range(0, 6, 2);
      chk("post_rst_sync", in_frame, 1'b1);
      send_range(6, 40, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
